serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter: DATA_W, 8, number of data bits per frame.
REQ-002 SHALL have port: CLK  input  1  sole clock, rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: serial_in  input  1  serial line, idle high, one bit per CLK.
REQ-005 SHALL have port: data_ack  input  1  consumer accepts the held byte.
REQ-006 SHALL have port: data_out  output  DATA_W  last good received byte.
REQ-007 SHALL have port: data_valid  output  1  data_out holds an unacknowledged byte.
REQ-008 SHALL have port: busy  output  1  a frame is in progress.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port: check_err  output  1  one-cycle pulse on a bad check bit.
REQ-011 SHALL have port: overrun  output  1  sticky; a good frame completed while data_valid was high and data_ack was low.

Function
REQ-012 SHALL receive frames ordered: start (0), DATA_W data bits MSB first, check bit, stop (1), one bit per CLK.
REQ-013 SHALL define the check bit as the inverse of data bit 0 (the last data bit received).
REQ-014 SHALL implement states IDLE, DATA, CHECK, STOP, WAIT_IDLE.
REQ-015 IDLE: serial_in=0 sampled -> DATA with bit counter cleared; serial_in=1 -> stay.
REQ-016 DATA: shift serial_in into LSB of shift register, counter +1; after DATA_W bits -> CHECK.
REQ-017 CHECK: capture the check bit -> STOP.
REQ-018 STOP: serial_in=1 -> IDLE; serial_in=0 -> frame_err pulse, frame discarded, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until serial_in=1 sampled, then -> IDLE; no start is detected in this state.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 Good frame: on the edge sampling the stop bit, data_out loads the byte and data_valid sets (latency: visible the cycle after the stop bit).
REQ-022 data_ack while data_valid=1 SHALL clear data_valid next edge; data_ack while data_valid=0 SHALL be ignored.
REQ-023 Good frame completing with data_ack=1 in the same cycle SHALL load the new byte, keep data_valid=1, and not set overrun.
REQ-024 Good frame completing with data_valid=1 and data_ack=0 SHALL overwrite data_out and set overrun; overrun clears only on RST.
REQ-025 Discarded frames SHALL leave data_out, data_valid and overrun unchanged.
REQ-026 Back-to-back frames (start bit directly after stop bit) SHALL be received without idle cycles.

Reset
REQ-027 RST=1 at a rising edge SHALL force IDLE, counter 0, data_out 0, data_valid 0, busy 0, frame_err 0, check_err 0, overrun 0.
REQ-028 RST mid-frame SHALL abort the frame with no error pulse; reception restarts at the next start bit after RST deasserts.

Configuration
REQ-029 With CHECK_BIT_EN defined: a check-bit mismatch SHALL pulse check_err on the stop-sample edge and discard the frame.
REQ-030 Without CHECK_BIT_EN: the check bit SHALL be sampled and ignored, and check_err SHALL be tied 0.
REQ-031 A frame with both a bad check bit and a bad stop bit SHALL pulse both flags and be discarded.

Structure
REQ-032 A shared package SHALL hold: the state enum, the START/STOP bit values, FRAME_LEN = DATA_W+3, and the check-bit rule as a function.
REQ-033 One sub-module, rx_hold_reg, SHALL own data_out, data_valid, data_ack handling and overrun.

Verification
REQ-034 Byte 0xA5 sent as bits 0,1,0,1,0,0,1,0,1,0,1 -> data_out=0xA5, data_valid=1 one cycle after the stop bit, no errors.
REQ-035 Byte 0x3C with stop bit 0 -> frame_err pulse, data_valid stays 0; line held low 5 cycles, then 1 -> next frame 0x81 received correctly.
REQ-036 With CHECK_BIT_EN: 0x01 with check bit 1 -> check_err pulse, frame discarded. Without CHECK_BIT_EN: same stimulus -> data_out=0x01.
REQ-037 Back-to-back 0x12 then 0x34 with no data_ack -> data_out=0x34 and overrun=1; repeated with data_ack on the second stop cycle -> overrun=0.
REQ-038 RST pulsed after 4 data bits of 0xFF -> all outputs 0, IDLE; next frame 0x55 -> data_out=0x55.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// line-level bit values, frame length and the check-bit rule.
package serial_frame_rx_pkg;

    // Receiver states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DATA      = 3'd1,
        ST_CHECK     = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Line levels of the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Default payload width and the resulting frame length (start + data + check + stop)
    localparam int DEFAULT_DATA_W = 8;
    localparam int FRAME_LEN      = DEFAULT_DATA_W + 3;

    // Frame length for an arbitrary payload width
    function automatic int frame_len(input int data_w);
        return data_w + 3;
    endfunction

    // The check bit is the inverse of the last data bit received (data bit 0)
    function automatic logic check_bit_of(input logic last_data_bit);
        return ~last_data_bit;
    endfunction

endpackage

// File: rtl/serial_frame_rx_hold_reg.sv
// rx_hold_reg: output holding register of the serial frame receiver.
// Owns the received byte, its valid flag, the consumer acknowledge and the
// sticky overrun flag.
module rx_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_ack,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;

    // Load a good byte, clear valid on acknowledge, latch overrun when an unread byte is overwritten
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_valid <= 1'b1;
            if (r_valid && !i_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: one-bit-per-clock frame receiver.
// Frame: start(0), DATA_W data bits MSB first, check bit, stop(1).
// Optional macro CHECK_BIT_EN enables check-bit verification (check_err);
// without it the check bit is skipped and check_err is tied low.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              serial_in,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              check_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_busy;
    logic              r_frame_err;
    logic              w_check_bad;
    logic              w_stop_ok;
    logic              w_load;

`ifdef CHECK_BIT_EN
    logic r_check;
    logic r_check_err;

    assign w_check_bad = (r_check != check_bit_of(r_shift[0]));
    assign check_err   = r_check_err;
`else
    assign w_check_bad = 1'b0;
    assign check_err   = 1'b0;
`endif

    assign w_stop_ok = (serial_in == STOP_BIT);
    // A good frame is handed to the holding register on the stop-sample edge
    assign w_load    = (r_state == ST_STOP) && w_stop_ok && !w_check_bad;

    // Frame reception state machine with registered busy and error pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef CHECK_BIT_EN
            r_check     <= 1'b0;
            r_check_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef CHECK_BIT_EN
            r_check_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        r_state <= ST_DATA;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    r_shift <= {r_shift[DATA_W-2:0], serial_in};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_busy  <= 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
`ifdef CHECK_BIT_EN
                    r_check <= serial_in;
`endif
                    r_state <= ST_STOP;
                    r_busy  <= 1'b1;
                end
                ST_STOP: begin
`ifdef CHECK_BIT_EN
                    r_check_err <= w_check_bad;
`endif
                    if (w_stop_ok) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // Line stuck low after the frame: wait for it to return high
                        r_frame_err <= 1'b1;
                        r_state     <= ST_WAIT_IDLE;
                        r_busy      <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (serial_in == STOP_BIT) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    rx_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .CLK         (CLK),
        .RST         (RST),
        .i_load      (w_load),
        .i_load_data (r_shift),
        .i_ack       (data_ack),
        .o_data      (data_out),
        .o_valid     (data_valid),
        .o_overrun   (overrun)
    );

    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule
